// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 64-bit combinational alu and its clients.
//   - ALU_* : operation codes driven on the alu cntrl input
//   - div_state_t : control states of the sequential divider
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] ALU_PASS_B   = 3'b000;
   localparam logic [2:0] ALU_ADD      = 3'b010;
   localparam logic [2:0] ALU_SUBTRACT = 3'b011;
   localparam logic [2:0] ALU_AND      = 3'b100;
   localparam logic [2:0] ALU_OR       = 3'b101;
   localparam logic [2:0] ALU_XOR      = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational WIDTH-bit ALU shared by the datapath and the divider.
// Ports:
//   A, B       : operands
//   cntrl      : operation (ALU_* from alu_pkg)
//   result     : operation result
//   carry_out  : carry of add; for subtract 1 iff A >= B (unsigned)
//   negative   : result MSB
//   zero       : result == 0
//   overflow   : signed overflow of add/subtract
// ---------------------------------------------------------------------------
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       cntrl,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             negative,
   output logic             zero,
   output logic             overflow
);

   logic [WIDTH:0] ext_sum;

   always_comb begin
      ext_sum   = '0;
      result    = '0;
      carry_out = 1'b0;
      overflow  = 1'b0;
      case (cntrl)
         ALU_PASS_B: result = B;
         ALU_ADD: begin
            ext_sum   = {1'b0, A} + {1'b0, B};
            result    = ext_sum[WIDTH-1:0];
            carry_out = ext_sum[WIDTH];
            overflow  = (A[WIDTH-1] == B[WIDTH-1]) && (result[WIDTH-1] != A[WIDTH-1]);
         end
         ALU_SUBTRACT: begin
            // A + ~B + 1: the carry out is the "no borrow" flag, i.e. A >= B
            ext_sum   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
            result    = ext_sum[WIDTH-1:0];
            carry_out = ext_sum[WIDTH];
            overflow  = (A[WIDTH-1] != B[WIDTH-1]) && (result[WIDTH-1] != A[WIDTH-1]);
         end
         ALU_AND: result = A & B;
         ALU_OR:  result = A | B;
         ALU_XOR: result = A ^ B;
         default: result = '0;
      endcase
   end

   assign negative = result[WIDTH-1];
   assign zero     = (result == '0);

endmodule

// File: rtl/alu_seq_divider.sv
// ---------------------------------------------------------------------------
// alu_seq_divider
// Multi-cycle unsigned WIDTH/WIDTH restoring divider (UDIV execution unit).
// One trial subtraction per clock is performed by the external shared alu.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   start, ready        : request / accept handshake (start sampled in IDLE)
//   dividend, divisor   : operands, sampled with an accepted start
//   done                : one-cycle pulse when results are valid
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : divisor was 0, held with the results
//   alu_A/B/cntrl       : drive the shared alu (quiet outside RUN)
//   alu_result/carry_out: alu response
// ---------------------------------------------------------------------------
module alu_seq_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [2:0]       alu_cntrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry_out
);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] q_reg_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] divisor_q;

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] rem_next;
   logic             last_iter;

   // rem < 2^k after k iterations, so dropping rem's MSB loses nothing
   assign shifted   = {rem_q[WIDTH-2:0], q_reg_q[WIDTH-1]};
   assign q_next    = {q_reg_q[WIDTH-2:0], alu_carry_out};
   assign rem_next  = alu_carry_out ? alu_result : shifted;
   assign last_iter = (count_q == CNT_W'(WIDTH - 1));

   assign ready = (state_q == IDLE);
   assign done  = (state_q == DONE);

   always_comb begin
      state_d   = state_q;
      alu_A     = '0;
      alu_B     = '0;
      alu_cntrl = ALU_PASS_B;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            alu_A     = shifted;
            alu_B     = divisor_q;
            alu_cntrl = ALU_SUBTRACT;
            if (last_iter) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         q_reg_q     <= '0;
         rem_q       <= '0;
         divisor_q   <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  divisor_q   <= divisor;
                  q_reg_q     <= dividend;
                  rem_q       <= '0;
                  count_q     <= '0;
                  div_by_zero <= 1'b0;
                  if (divisor == '0) begin
                     div_by_zero <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                  end
               end
            end
            RUN: begin
               rem_q   <= rem_next;
               q_reg_q <= q_next;
               count_q <= count_q + CNT_W'(1);
               if (last_iter) begin
                  quotient  <= q_next;
                  remainder <= rem_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_divider
// Bench for alu_seq_divider wired to the shared alu. Expected results come
// from the plain / and % operators; handshake timing and the alu bus are
// checked every cycle of each operation.
// ---------------------------------------------------------------------------
module tb_alu_seq_divider;
   import alu_pkg::*;

   localparam int WIDTH = 64;
   localparam int CNT_W = 7;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic [WIDTH-1:0] alu_A;
   logic [WIDTH-1:0] alu_B;
   logic [2:0]       alu_cntrl;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry_out;
   logic             alu_negative;
   logic             alu_zero;
   logic             alu_overflow;

   int n_chk = 0;
   int n_bad = 0;

   alu #(.WIDTH(WIDTH)) u_alu (
      .A         (alu_A),
      .B         (alu_B),
      .cntrl     (alu_cntrl),
      .result    (alu_result),
      .carry_out (alu_carry_out),
      .negative  (alu_negative),
      .zero      (alu_zero),
      .overflow  (alu_overflow)
   );

   alu_seq_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .dividend      (dividend),
      .divisor       (divisor),
      .ready         (ready),
      .done          (done),
      .quotient      (quotient),
      .remainder     (remainder),
      .div_by_zero   (div_by_zero),
      .alu_A         (alu_A),
      .alu_B         (alu_B),
      .alu_cntrl     (alu_cntrl),
      .alu_result    (alu_result),
      .alu_carry_out (alu_carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Shared alu must be quiet (pass-B of zero) whenever the divider is not running.
   task automatic chk_quiet(input string tag);
      chk({tag, "_cntrl"}, 64'(alu_cntrl), 64'(ALU_PASS_B));
      chk({tag, "_A"}, alu_A, '0);
      chk({tag, "_B"}, alu_B, '0);
   endtask

   // Runs one division. ign_at >= 0 pulses a competing start in that RUN
   // cycle; rst_at >= 0 pulses reset in that RUN cycle and expects an abort.
   task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int ign_at, input int rst_at);
      logic [WIDTH-1:0] exp_q, exp_r;
      logic             exp_z;
      int               n;
      exp_z = (b == '0);
      exp_q = exp_z ? '1 : a / b;
      exp_r = exp_z ? a : a % b;

      chk("idle_ready", 64'(ready), 64'd1);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = {$urandom(), $urandom()};
      divisor  = {$urandom(), $urandom()};
      chk("ready_drop", 64'(ready), 64'd0);

      n = 0;
      while (!done && n < 200) begin
         chk("run_cntrl", 64'(alu_cntrl), 64'(ALU_SUBTRACT));
         chk("run_B", alu_B, b);
         start = (n == ign_at);
         if (start) begin
            dividend = 64'd50;
            divisor  = 64'd5;
         end
         if (n == rst_at) reset_n = 1'b0;
         tick();
         start = 1'b0;
         n++;
         if (!reset_n) begin
            reset_n = 1'b1;
            chk("abort_ready", 64'(ready), 64'd1);
            chk("abort_done", 64'(done), 64'd0);
            chk("abort_quot", quotient, '0);
            chk("abort_rem", remainder, '0);
            chk("abort_dbz", 64'(div_by_zero), 64'd0);
            for (int i = 0; i < 80; i++) begin
               chk("abort_no_done", 64'(done), 64'd0);
               chk_quiet("abort_quiet");
               tick();
            end
            return;
         end
      end

      chk("latency", 64'(n), exp_z ? 64'd0 : 64'(WIDTH));
      chk("done_ready", 64'(ready), 64'd0);
      chk("quotient", quotient, exp_q);
      chk("remainder", remainder, exp_r);
      chk("div_by_zero", 64'(div_by_zero), 64'(exp_z));
      chk_quiet("done_quiet");
      tick();
      chk("done_pulse", 64'(done), 64'd0);
      chk("back_ready", 64'(ready), 64'd1);
      chk("hold_quot", quotient, exp_q);
      chk("hold_rem", remainder, exp_r);
      chk_quiet("idle_quiet");
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      reset_n  = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_quot", quotient, '0);
      chk("rst_rem", remainder, '0);
      chk("rst_dbz", 64'(div_by_zero), 64'd0);
      chk_quiet("rst_quiet");
      reset_n = 1'b1;
      tick();

      // start accepted in reset must not launch anything
      reset_n = 1'b0;
      start   = 1'b1;
      divisor = 64'd3;
      tick();
      start   = 1'b0;
      reset_n = 1'b1;
      chk("start_in_rst", 64'(ready), 64'd1);
      tick();

      run_div(64'd100, 64'd7, -1, -1);
      run_div(64'd5, 64'd9, -1, -1);
      run_div('1, '1, -1, -1);
      run_div('1, 64'd1, -1, -1);
      run_div('1, 64'h8000000000000001, -1, -1);
      run_div(64'd1234, 64'd0, -1, -1);
      run_div(64'd100, 64'd7, 10, -1);
      run_div(64'd50, 64'd5, -1, -1);
      run_div(64'd100, 64'd7, -1, 20);
      run_div(64'd100, 64'd7, -1, -1);

      for (int k = 0; k < 100; k++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()} >> $urandom_range(0, 63);
         if (k % 10 == 3) ra = ra >> $urandom_range(0, 63);
         if (k % 25 == 7) rb = '0;
         run_div(ra, rb, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
